// File: rtl/imm_gen_pkg.sv
// ----------------------------------------------------------------------------
// imm_gen_pkg
// Shared definitions for the pipelined RISC-V immediate generator:
//   - FMT_W   : width of the format-code field
//   - fmt_e   : format codes R/I/S/B/U/J/Z/X
//   - OPC_*   : major opcode values, i.e. instruction bits [6:2]
// ----------------------------------------------------------------------------
package imm_gen_pkg;

  localparam int FMT_W = 3;

  typedef enum logic [FMT_W-1:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5,
    FMT_Z = 3'd6,
    FMT_X = 3'd7
  } fmt_e;

  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

endpackage

// File: rtl/imm_gen_dec.sv
// ----------------------------------------------------------------------------
// imm_gen_dec
// Purely combinational immediate decoder.
//   i_inst    [29:0]     instruction bits [31:2] (bits [1:0] are always 2'b11)
//   o_imm     [XLEN-1:0] sign-extended immediate (zero-extended for Z format)
//   o_fmt     [2:0]      format code (fmt_e)
//   o_illegal            major opcode not recognised
// Optional feature macro: IMM_GEN_ZICSR_EN -- when defined, SYSTEM words with
// funct3[2]=1 decode as format Z carrying the zero-extended 5-bit CSR zimm.
// ----------------------------------------------------------------------------
module imm_gen_dec
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [29:0]      i_inst,
  output logic [XLEN-1:0]  o_imm,
  output logic [FMT_W-1:0] o_fmt,
  output logic             o_illegal
);

  // i_inst[k - O] holds instruction bit k, so the slices below read like the ISA manual.
  localparam int O = 2;

  logic [4:0]  w_opc;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm32;
  fmt_e        w_fmt;

  assign w_opc   = i_inst[6-O:2-O];
  assign w_imm_i = {{20{i_inst[31-O]}}, i_inst[31-O:20-O]};
  assign w_imm_s = {{20{i_inst[31-O]}}, i_inst[31-O:25-O], i_inst[11-O:7-O]};
  assign w_imm_b = {{19{i_inst[31-O]}}, i_inst[31-O], i_inst[7-O], i_inst[30-O:25-O],
                    i_inst[11-O:8-O], 1'b0};
  assign w_imm_u = {i_inst[31-O:12-O], 12'b0};
  assign w_imm_j = {{11{i_inst[31-O]}}, i_inst[31-O], i_inst[19-O:12-O], i_inst[20-O],
                    i_inst[30-O:21-O], 1'b0};

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves a
    // value unassigned; a missing default here would infer a latch.
    w_imm32   = '0;
    w_fmt     = FMT_X;
    o_illegal = 1'b0;
    case (w_opc)
      OPC_LOAD, OPC_MISC_MEM, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: begin
        w_imm32 = w_imm_i;
        w_fmt   = FMT_I;
      end
      OPC_STORE:            begin w_imm32 = w_imm_s; w_fmt = FMT_S; end
      OPC_BRANCH:           begin w_imm32 = w_imm_b; w_fmt = FMT_B; end
      OPC_LUI, OPC_AUIPC:   begin w_imm32 = w_imm_u; w_fmt = FMT_U; end
      OPC_JAL:              begin w_imm32 = w_imm_j; w_fmt = FMT_J; end
      OPC_OP:               begin w_imm32 = '0;      w_fmt = FMT_R; end
      default:              o_illegal = 1'b1;
    endcase

    // All 32-bit immediates are signed; widening the signed value replicates bit 31.
    o_imm = XLEN'($signed(w_imm32));

`ifdef IMM_GEN_ZICSR_EN
    // CSR immediate forms (csrrwi/csrrsi/csrrci) carry an unsigned rs1-field zimm.
    if (w_opc == OPC_SYSTEM && i_inst[14-O]) begin
      w_fmt = FMT_Z;
      o_imm = XLEN'(i_inst[19-O:15-O]);
    end
`else
    // Without CSR support every SYSTEM word keeps the I-format decode above.
`endif

    o_fmt = w_fmt;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Registered immediate generator with a valid/ready handshake and a two-entry
// output/skid buffer (full throughput under back-pressure, 1-cycle latency).
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               discard both buffer entries (and any word taken this cycle)
//   i_in_valid/o_in_ready input handshake; o_in_ready = !skid_valid (registered)
//   i_in_inst  [29:0]     instruction bits [31:2]
//   i_in_tag   [TAG_W-1:0] sideband carried with the word
//   o_out_valid/i_out_ready output handshake
//   o_out_imm/o_out_fmt/o_out_illegal/o_out_tag  decoded word on the output
// Optional feature macro: IMM_GEN_ZICSR_EN (handled inside imm_gen_dec).
// ----------------------------------------------------------------------------
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [29:0]      i_in_inst,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_imm,
  output logic [FMT_W-1:0] o_out_fmt,
  output logic             o_out_illegal,
  output logic [TAG_W-1:0] o_out_tag
);

  logic [XLEN-1:0]  w_dec_imm;
  logic [FMT_W-1:0] w_dec_fmt;
  logic             w_dec_illegal;
  logic             w_in_fire, w_out_fire;

  logic             r_out_valid, r_out_illegal;
  logic [XLEN-1:0]  r_out_imm;
  logic [FMT_W-1:0] r_out_fmt;
  logic [TAG_W-1:0] r_out_tag;

  logic             r_skid_valid, r_skid_illegal;
  logic [XLEN-1:0]  r_skid_imm;
  logic [FMT_W-1:0] r_skid_fmt;
  logic [TAG_W-1:0] r_skid_tag;

  imm_gen_dec #(.XLEN(XLEN)) u_dec (
    .i_inst    (i_in_inst),
    .o_imm     (w_dec_imm),
    .o_fmt     (w_dec_fmt),
    .o_illegal (w_dec_illegal)
  );

  // Skid occupancy is a flop, so ready is registered without extra state.
  assign o_in_ready = ~r_skid_valid;
  assign w_in_fire  = i_in_valid & o_in_ready;
  assign w_out_fire = r_out_valid & i_out_ready;

  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (i_rst) begin
      // NOTE: data registers are cleared as well as the valid bits because the
      // output fields must read zero straight out of reset.
      r_out_valid    <= 1'b0;
      r_out_imm      <= '0;
      r_out_fmt      <= '0;
      r_out_illegal  <= 1'b0;
      r_out_tag      <= '0;
      r_skid_valid   <= 1'b0;
      r_skid_imm     <= '0;
      r_skid_fmt     <= '0;
      r_skid_illegal <= 1'b0;
      r_skid_tag     <= '0;
    end else if (i_flush) begin
      // Redirect: both entries drop, and a word accepted this cycle is never stored.
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (r_skid_valid) begin
      // in_ready is low, so only a drain of the skid into the output can occur.
      if (w_out_fire) begin
        r_out_imm     <= r_skid_imm;
        r_out_fmt     <= r_skid_fmt;
        r_out_illegal <= r_skid_illegal;
        r_out_tag     <= r_skid_tag;
        r_skid_valid  <= 1'b0;
      end
    end else if (w_in_fire && (!r_out_valid || w_out_fire)) begin
      r_out_valid   <= 1'b1;
      r_out_imm     <= w_dec_imm;
      r_out_fmt     <= w_dec_fmt;
      r_out_illegal <= w_dec_illegal;
      r_out_tag     <= i_in_tag;
    end else if (w_in_fire) begin
      // Output is stalled: park the new word behind it so order is preserved.
      r_skid_valid   <= 1'b1;
      r_skid_imm     <= w_dec_imm;
      r_skid_fmt     <= w_dec_fmt;
      r_skid_illegal <= w_dec_illegal;
      r_skid_tag     <= i_in_tag;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid   = r_out_valid;
  assign o_out_imm     = r_out_imm;
  assign o_out_fmt     = r_out_fmt;
  assign o_out_illegal = r_out_illegal;
  assign o_out_tag     = r_out_tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Self-checking bench for imm_gen_pipe: a table of instruction vectors streamed
// through an XLEN=32 instance with a scoreboard queue, hand-written
// back-pressure / flush / reset sequences, and an XLEN=64 instance for
// sign-extension to 64 bits. Expected CSR-immediate results follow the
// IMM_GEN_ZICSR_EN macro.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;
  import imm_gen_pkg::*;

  typedef struct {
    logic [31:0]      inst;
    logic [31:0]      imm;
    logic [FMT_W-1:0] fmt;
    logic             ill;
  } vec_t;

  typedef struct {
    logic [31:0]      imm;
    logic [FMT_W-1:0] fmt;
    logic             ill;
    logic [31:0]      tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst, flush;

  // XLEN = 32 instance
  logic             in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [29:0]      in_inst;
  logic [31:0]      in_tag, out_imm, out_tag;
  logic [FMT_W-1:0] out_fmt;

  // XLEN = 64 instance
  logic             v64, rdy64, ready64_in, ov64, ill64;
  logic [29:0]      inst64;
  logic [31:0]      tag64, otag64;
  logic [63:0]      imm64;
  logic [FMT_W-1:0] fmt64;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  exp_t cur_exp;
  vec_t vecs[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_in_inst(in_inst), .i_in_tag(in_tag),
    .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_imm(out_imm), .o_out_fmt(out_fmt),
    .o_out_illegal(out_illegal), .o_out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .i_clk(clk), .i_rst(rst), .i_flush(flush),
    .i_in_valid(v64), .o_in_ready(rdy64),
    .i_in_inst(inst64), .i_in_tag(tag64),
    .o_out_valid(ov64), .i_out_ready(ready64_in),
    .o_out_imm(imm64), .o_out_fmt(fmt64),
    .o_out_illegal(ill64), .o_out_tag(otag64)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present one word on the XLEN=32 input and record what it must decode to.
  task automatic offer(input logic [31:0] inst, input logic [31:0] tag,
                       input logic [31:0] imm, input logic [FMT_W-1:0] fmt,
                       input logic ill);
    in_valid = 1'b1;
    in_inst  = inst[31:2];
    in_tag   = tag;
    cur_exp  = '{imm: imm, fmt: fmt, ill: ill, tag: tag};
  endtask

  // Resolve the handshakes of the coming edge against the scoreboard, then
  // advance one clock and settle 1 time unit past the edge.
  task automatic cycle();
    exp_t e;
    logic in_fire, out_fire;
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (out_fire) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          e = sb.pop_front();
          check("out_tag", out_tag, e.tag);
          check("out_imm", out_imm, e.imm);
          check("out_fmt", out_fmt, e.fmt);
          check("out_illegal", out_illegal, e.ill);
        end
      end
      if (in_fire) sb.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_out_imm"}, out_imm, 32'h0);
    check({tag, "_out_fmt"}, out_fmt, 3'd0);
    check({tag, "_out_illegal"}, out_illegal, 1'b0);
    check({tag, "_out_tag"}, out_tag, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs.push_back('{inst: 32'hFFF00013, imm: 32'hFFFFFFFF, fmt: FMT_I, ill: 1'b0});
    vecs.push_back('{inst: 32'hFE000FE3, imm: 32'hFFFFFFFE, fmt: FMT_B, ill: 1'b0});
    vecs.push_back('{inst: 32'hD545506F, imm: 32'hFFF55554, fmt: FMT_J, ill: 1'b0});
    vecs.push_back('{inst: 32'hABEAA523, imm: 32'hFFFFFAAA, fmt: FMT_S, ill: 1'b0});
    vecs.push_back('{inst: 32'h00812083, imm: 32'h00000008, fmt: FMT_I, ill: 1'b0});
    vecs.push_back('{inst: 32'h7FF08067, imm: 32'h000007FF, fmt: FMT_I, ill: 1'b0});
    vecs.push_back('{inst: 32'h0FF0000F, imm: 32'h000000FF, fmt: FMT_I, ill: 1'b0});
    vecs.push_back('{inst: 32'h00112423, imm: 32'h00000008, fmt: FMT_S, ill: 1'b0});
    vecs.push_back('{inst: 32'h00000463, imm: 32'h00000008, fmt: FMT_B, ill: 1'b0});
    vecs.push_back('{inst: 32'h12345037, imm: 32'h12345000, fmt: FMT_U, ill: 1'b0});
    vecs.push_back('{inst: 32'hFFFFF097, imm: 32'hFFFFF000, fmt: FMT_U, ill: 1'b0});
    vecs.push_back('{inst: 32'h00B50533, imm: 32'h00000000, fmt: FMT_R, ill: 1'b0});
    vecs.push_back('{inst: 32'h00000073, imm: 32'h00000000, fmt: FMT_I, ill: 1'b0});
`ifdef IMM_GEN_ZICSR_EN
    vecs.push_back('{inst: 32'h3401D073, imm: 32'h00000003, fmt: FMT_Z, ill: 1'b0});
`else
    vecs.push_back('{inst: 32'h3401D073, imm: 32'h00000340, fmt: FMT_I, ill: 1'b0});
`endif
    vecs.push_back('{inst: 32'h0000007F, imm: 32'h00000000, fmt: FMT_X, ill: 1'b1});
    vecs.push_back('{inst: 32'h0000002B, imm: 32'h00000000, fmt: FMT_X, ill: 1'b1});

    rst = 1'b1; flush = 1'b0;
    in_valid = 1'b0; in_inst = '0; in_tag = '0; out_ready = 1'b1;
    v64 = 1'b0; inst64 = '0; tag64 = '0; ready64_in = 1'b1;
    cur_exp = '{imm: '0, fmt: '0, ill: 1'b0, tag: '0};
    cycle(); cycle();
    rst = 1'b0;
    check_reset_state("reset");

    // Streaming at full rate: each word must appear the cycle after it is taken.
    for (int i = 0; i < vecs.size(); i++) begin
      offer(vecs[i].inst, 32'h100 + 32'(i) * 4, vecs[i].imm, vecs[i].fmt, vecs[i].ill);
      cycle();
      check("stream_out_valid", out_valid, 1'b1);
      check("stream_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    for (int k = 0; k < 8 && sb.size() > 0; k++) cycle();
    check("stream_drained", sb.size(), 0);
    check("stream_idle_valid", out_valid, 1'b0);

    // Back-pressure: two words fill output + skid, a third waits at the input.
    out_ready = 1'b0;
    offer(32'h00812083, 32'h10, 32'h8, FMT_I, 1'b0); cycle();
    offer(32'h00000463, 32'h14, 32'h8, FMT_B, 1'b0); cycle();
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_hold_tag", out_tag, 32'h10);
    offer(32'h00B50533, 32'h18, 32'h0, FMT_R, 1'b0); cycle();
    check("bp_hold_tag2", out_tag, 32'h10);
    check("bp_hold_imm", out_imm, 32'h8);
    check("bp_hold_fmt", out_fmt, FMT_I);
    cycle();
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_in_ready_still_low", in_ready, 1'b0);
    out_ready = 1'b1;
    cycle();
    check("bp_second_tag", out_tag, 32'h14);
    check("bp_in_ready_back", in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    check("bp_third_tag", out_tag, 32'h18);
    cycle();
    check("bp_empty", out_valid, 1'b0);
    check("bp_sb_empty", sb.size(), 0);

    // Flush with both entries full (input offered but blocked).
    out_ready = 1'b0;
    offer(32'hFFF00013, 32'h20, 32'hFFFFFFFF, FMT_I, 1'b0); cycle();
    offer(32'hFFF00013, 32'h24, 32'hFFFFFFFF, FMT_I, 1'b0); cycle();
    check("fl1_full", in_ready, 1'b0);
    offer(32'hFFF00013, 32'h28, 32'hFFFFFFFF, FMT_I, 1'b0);
    flush = 1'b1; cycle(); flush = 1'b0; in_valid = 1'b0;
    check("fl1_out_valid", out_valid, 1'b0);
    check("fl1_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cycle(); cycle(); cycle();
    check("fl1_no_output", out_valid, 1'b0);

    // Flush while a word is handshaken in the same cycle: that word is dropped too.
    out_ready = 1'b0;
    offer(32'hFFF00013, 32'h30, 32'hFFFFFFFF, FMT_I, 1'b0); cycle();
    offer(32'h00000463, 32'h34, 32'h8, FMT_B, 1'b0);
    flush = 1'b1; cycle(); flush = 1'b0; in_valid = 1'b0;
    check("fl2_out_valid", out_valid, 1'b0);
    check("fl2_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    cycle(); cycle();
    check("fl2_no_output", out_valid, 1'b0);

    // Reset mid-stream with both entries occupied.
    out_ready = 1'b0;
    offer(32'hD545506F, 32'h40, 32'hFFF55554, FMT_J, 1'b0); cycle();
    offer(32'hABEAA523, 32'h44, 32'hFFFFFAAA, FMT_S, 1'b0); cycle();
    in_valid = 1'b0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check_reset_state("midrst");
    out_ready = 1'b1;
    cycle(); cycle();
    check("midrst_no_output", out_valid, 1'b0);

    // XLEN = 64: sign extension from bit 31 all the way to bit 63.
    v64 = 1'b1; inst64 = 30'(32'h12345037 >> 2); tag64 = 32'h50;
    cycle();
    check("x64_lui_valid", ov64, 1'b1);
    check("x64_lui_pos_imm", imm64, 64'h0000000012345000);
    check("x64_lui_pos_fmt", fmt64, FMT_U);
    inst64 = 30'(32'h80000037 >> 2); tag64 = 32'h54;
    cycle();
    check("x64_lui_neg_imm", imm64, 64'hFFFFFFFF80000000);
    check("x64_lui_neg_tag", otag64, 32'h54);
    inst64 = 30'(32'hFFF00013 >> 2); tag64 = 32'h58;
    cycle();
    check("x64_addi_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    check("x64_addi_fmt", fmt64, FMT_I);
    v64 = 1'b0;
    cycle();
    check("x64_idle", ov64, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
